lda_cmd_if: RTL and testbench
=============================

LDA_CMD_IF -- requirements
Module: lda_cmd_if

Interface
REQ-001 Parameter X_W, 9, x-coordinate width.
REQ-002 Parameter Y_W, 8, y-coordinate width.
REQ-003 Parameter COLOR_W, 3, pixel colour width.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_address  input  3  Avalon-MM slave word address.
REQ-007 s_read  input  1  Avalon read strobe.
REQ-008 s_write  input  1  Avalon write strobe.
REQ-009 s_writedata  input  32  write data.
REQ-010 s_readdata  output  32  read data, valid in the cycle a read is accepted.
REQ-011 s_waitrequest  output  1  stall the current access.
REQ-012 lda_start  output  1  one-cycle pulse that launches a line draw.
REQ-013 lda_done  input  1  one-cycle completion pulse from the line engine.
REQ-014 x0, x1  output  X_W  line start/end x; y0, y1  output  Y_W  line start/end y.
REQ-015 color  output  COLOR_W  line colour.

Function
REQ-016 Register map SHALL be: 0 MODE (bit0: 0=stall, 1=poll, R/W); 1 STATUS (bit0=busy, RO); 2 GO (WO, reads 0); 3 START (x0=bits[8:0], y0=bits[16:9]); 4 END (x1, y1, same packing); 5 COLOR (bits[2:0]).
REQ-017 Addresses 6-7 SHALL read 0; writes to them SHALL be ignored.
REQ-018 An access SHALL be accepted in a cycle where (s_read|s_write) & !s_waitrequest.
REQ-019 Reads SHALL be zero-wait-state: s_readdata is combinational from the address; unused bits are 0.
REQ-020 The FSM SHALL have states S_IDLE, S_START, S_BUSY.
REQ-021 S_IDLE -> S_START on an accepted write to GO (data ignored); otherwise stay in S_IDLE.
REQ-022 S_START SHALL assert lda_start for exactly that one cycle, then go to S_BUSY unconditionally.
REQ-023 S_BUSY -> S_IDLE in the cycle after lda_done=1; otherwise stay in S_BUSY.
REQ-024 lda_done SHALL be ignored in S_IDLE and S_START.
REQ-025 STATUS.busy SHALL be 1 in S_START and S_BUSY, and 0 in S_IDLE.
REQ-026 Stall mode: s_waitrequest SHALL be (state!=S_IDLE)&(s_read|s_write), so every access stalls until the cycle the FSM is back in S_IDLE.
REQ-027 Poll mode: s_waitrequest SHALL be 0; while busy, writes to GO, START, END and COLOR SHALL be ignored; MODE writes and all reads SHALL proceed.
REQ-028 x0/y0/x1/y1/color SHALL come directly from the registers and SHALL be stable from S_START until the FSM returns to S_IDLE.
REQ-029 A GO write with lda_done asserted in the same cycle (in S_IDLE) SHALL start a new draw normally.
REQ-030 Write latency: a register update SHALL be visible on outputs and readback in the cycle after acceptance.

Reset
REQ-031 On reset, the FSM SHALL be in S_IDLE; MODE, START, END and COLOR SHALL be 0; lda_start SHALL be 0.
REQ-032 Reset mid-draw SHALL abandon the draw without a lda_start pulse; the line engine shares the same reset.
REQ-033 s_waitrequest SHALL be 0 and s_readdata SHALL be 0 while reset is asserted.

Structure
REQ-034 Package lda_pkg SHALL hold X_W/Y_W/COLOR_W defaults, register address constants, field bit positions and the FSM state enum.
REQ-035 The register file and read mux SHALL form one sub-module, lda_cmd_regs; the FSM and waitrequest logic SHALL live in lda_cmd_if.

Verification
REQ-036 Write START=0x00C8_0A (x0=10, y0=100), END (x1=200, y1=50), COLOR=5, then GO -> lda_start high for exactly 1 cycle, 1 cycle after GO is accepted; outputs 10/100/200/50/5.
REQ-037 Stall mode: read STATUS during busy -> s_waitrequest held until lda_done+1 cycle, then returns 0.
REQ-038 Poll mode: read STATUS while busy -> 1 with no stall; a START write while busy is ignored, so x0 stays 10; after done, STATUS reads 0.
REQ-039 Pulse lda_done while idle, then issue GO and pulse lda_done in the S_START cycle -> no state change from either pulse, and the FSM remains in S_BUSY.
REQ-040 Assert reset while in S_BUSY -> next cycle S_IDLE, STATUS=0, MODE=0, all coordinates 0, no lda_start pulse.
REQ-041 Read address 7 and GO -> 0; write address 6 -> no register change.

Source files
------------

// File: rtl/lda_pkg.sv
`timescale 1ns/1ps
// lda_pkg: shared constants for the line-draw command interface.
//   - default coordinate / colour widths
//   - Avalon-MM bus widths and register word addresses
//   - bit positions of single-bit fields
//   - command FSM state encoding
package lda_pkg;

    localparam int X_W_DEF     = 9;
    localparam int Y_W_DEF     = 8;
    localparam int COLOR_W_DEF = 3;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_MODE   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_GO     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_START  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_END    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_COLOR  = 3'd5;

    // MODE.bit0 selects poll (1) or stall (0); STATUS.bit0 is busy.
    localparam int MODE_POLL_BIT   = 0;
    localparam int STATUS_BUSY_BIT = 0;
    // Points pack x in the low bits and y directly above it.
    localparam int PT_X_LSB        = 0;
    localparam int COLOR_LSB       = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/lda_cmd_bus_if.sv
`timescale 1ns/1ps
// lda_cmd_bus_if: Avalon-MM slave bus for the line-draw command block.
//   slave  modport: the command block (takes address/strobes/data,
//                   returns readdata/waitrequest)
//   master modport: the CPU side driving accesses
interface lda_cmd_bus_if;
    import lda_pkg::*;

    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [DATA_W-1:0] s_readdata;
    logic              s_waitrequest;

    modport slave (
        input  s_address, s_read, s_write, s_writedata,
        output s_readdata, s_waitrequest
    );

    modport master (
        output s_address, s_read, s_write, s_writedata,
        input  s_readdata, s_waitrequest
    );

endinterface

// File: rtl/lda_cmd_regs.sv
`timescale 1ns/1ps
// lda_cmd_regs: register file and read mux of the line-draw command block.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   wr_en            a write was accepted this cycle
//   busy             draw in progress: only MODE may be written
//   address          word address of the access
//   writedata        write data
//   readdata         combinational read data (0 while reset is high)
//   mode_poll        MODE.bit0
//   x0, y0, x1, y1   line endpoints straight from the registers
//   color            line colour straight from the register
module lda_cmd_regs
    import lda_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic               busy,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  writedata,
    output logic [DATA_W-1:0]  readdata,
    output logic               mode_poll,
    output logic [X_W-1:0]     x0,
    output logic [Y_W-1:0]     y0,
    output logic [X_W-1:0]     x1,
    output logic [Y_W-1:0]     y1,
    output logic [COLOR_W-1:0] color
);

    localparam int PT_Y_LSB = PT_X_LSB + X_W;
    localparam int PT_W     = X_W + Y_W;

    logic               mode_reg;
    logic [X_W-1:0]     x0_reg, x1_reg;
    logic [Y_W-1:0]     y0_reg, y1_reg;
    logic [COLOR_W-1:0] color_reg;
    logic [DATA_W-1:0]  rd_mux;

    // Upper write-data bits carry no field.
    logic unused_wdata;
    assign unused_wdata = ^writedata[DATA_W-1:PT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg  <= 1'b0;
            x0_reg    <= '0;
            y0_reg    <= '0;
            x1_reg    <= '0;
            y1_reg    <= '0;
            color_reg <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_MODE: mode_reg <= writedata[MODE_POLL_BIT];
                // Drawing parameters are frozen while a line is in flight.
                ADDR_START: if (!busy) begin
                    x0_reg <= writedata[PT_X_LSB +: X_W];
                    y0_reg <= writedata[PT_Y_LSB +: Y_W];
                end
                ADDR_END: if (!busy) begin
                    x1_reg <= writedata[PT_X_LSB +: X_W];
                    y1_reg <= writedata[PT_Y_LSB +: Y_W];
                end
                ADDR_COLOR: if (!busy) color_reg <= writedata[COLOR_LSB +: COLOR_W];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_MODE:   rd_mux[MODE_POLL_BIT]      = mode_reg;
            ADDR_STATUS: rd_mux[STATUS_BUSY_BIT]    = busy;
            ADDR_START:  rd_mux[PT_W-1:0]           = {y0_reg, x0_reg};
            ADDR_END:    rd_mux[PT_W-1:0]           = {y1_reg, x1_reg};
            ADDR_COLOR:  rd_mux[COLOR_LSB +: COLOR_W] = color_reg;
            default:     rd_mux = '0;
        endcase
    end

    assign readdata  = reset ? '0 : rd_mux;
    assign mode_poll = mode_reg;
    assign x0        = x0_reg;
    assign y0        = y0_reg;
    assign x1        = x1_reg;
    assign y1        = y1_reg;
    assign color     = color_reg;

endmodule

// File: rtl/lda_cmd_if.sv
`timescale 1ns/1ps
// lda_cmd_if: Avalon-MM command front end for a line-draw engine.
// A GO write launches a draw (one-cycle lda_start), the block stays busy
// until the engine pulses lda_done. In stall mode any access made while
// busy is held with waitrequest; in poll mode nothing stalls and writes
// to the drawing registers are dropped while busy.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   bus                 Avalon-MM slave (lda_cmd_bus_if.slave)
//   lda_start           draw launch pulse
//   lda_done            draw completion pulse from the engine
//   x0, y0, x1, y1      line endpoints
//   color               line colour
module lda_cmd_if
    import lda_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    lda_cmd_bus_if.slave       bus,
    output logic               lda_start,
    input  logic               lda_done,
    output logic [X_W-1:0]     x0,
    output logic [Y_W-1:0]     y0,
    output logic [X_W-1:0]     x1,
    output logic [Y_W-1:0]     y1,
    output logic [COLOR_W-1:0] color
);

    state_t state_reg, state_next;
    logic   busy;
    logic   mode_poll;
    logic   wait_req;
    logic   wr_accept;
    logic   go_write;
    logic   start_comb;

    assign busy = (state_reg != S_IDLE);

    always_comb begin
        wait_req = 1'b0;
        if (!reset && !mode_poll)
            wait_req = busy & (bus.s_read | bus.s_write);
    end
    assign bus.s_waitrequest = wait_req;

    assign wr_accept = bus.s_write & ~wait_req & ~reset;
    // A GO while busy can only be accepted in poll mode, where it is dropped.
    assign go_write  = wr_accept & (bus.s_address == ADDR_GO) & ~busy;

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start_comb = 1'b0;
        case (state_reg)
            S_IDLE:  if (go_write) state_next = S_START;
            S_START: begin
                start_comb = 1'b1;
                state_next = S_BUSY;
            end
            S_BUSY:  if (lda_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Reset arriving in S_START must not leak a launch pulse.
    assign lda_start = start_comb & ~reset;

    lda_cmd_regs #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .COLOR_W (COLOR_W)
    ) u_regs (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_accept),
        .busy      (busy),
        .address   (bus.s_address),
        .writedata (bus.s_writedata),
        .readdata  (bus.s_readdata),
        .mode_poll (mode_poll),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .color     (color)
    );

endmodule

// File: tb/tb_lda_cmd_if.sv
`timescale 1ns/1ps
module tb_lda_cmd_if;
    import lda_pkg::*;

    localparam int WAIT_LIMIT = 200;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       lda_start;
    logic       lda_done;
    logic [8:0] x0, x1;
    logic [7:0] y0, y1;
    logic [2:0] color;

    lda_cmd_bus_if bus();

    lda_cmd_if dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .lda_start (lda_start),
        .lda_done  (lda_done),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .color     (color)
    );

    always #5 clk = ~clk;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   start_cnt = 0;
    int   done_cyc  = -1;
    int   acc_cyc   = 0;
    bit   done_force = 1'b0;
    bit   auto_done  = 1'b1;
    int   done_delay = 6;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lda_start) start_cnt <= start_cnt + 1;
        if (lda_done)  done_cyc  <= cyc;
    end

    // Line-engine model: pulses done done_delay cycles after a launch,
    // or on request from the stimulus.
    initial begin
        int cnt = 0;
        lda_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            lda_done = done_force;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) lda_done = 1'b1;
            end else if (lda_start && auto_done) begin
                cnt = done_delay;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data, input bit with_done);
        int n = 0;
        @(negedge clk);
        bus.s_address   = addr;
        bus.s_writedata = data;
        bus.s_write     = 1'b1;
        #1;
        while (bus.s_waitrequest && n < WAIT_LIMIT) begin
            @(negedge clk); #1; n++;
        end
        if (bus.s_waitrequest) check("write_wait_bound", {31'd0, bus.s_waitrequest}, 32'd0);
        if (with_done) done_force = 1'b1;
        $display("wr  addr=%0d data=0x%0h stalls=%0d", addr, data, n);
        @(posedge clk); #1;
        bus.s_write = 1'b0;
        if (with_done) begin
            @(negedge clk);
            done_force = 1'b0;
        end
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string tag,
                            output int stalls);
        exp_t e;
        int   n = 0;
        exp_q.push_back('{tag: tag, val: exp});
        @(negedge clk);
        bus.s_address = addr;
        bus.s_read    = 1'b1;
        #1;
        while (bus.s_waitrequest && n < WAIT_LIMIT) begin
            @(negedge clk); #1; n++;
        end
        if (bus.s_waitrequest) check({tag, "_wait_bound"}, {31'd0, bus.s_waitrequest}, 32'd0);
        acc_cyc = cyc;
        e = exp_q.pop_front();
        $display("rd  addr=%0d stalls=%0d", addr, n);
        check(e.tag, bus.s_readdata, e.val);
        stalls = n;
        @(posedge clk); #1;
        bus.s_read = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [8:0] ex0, input logic [7:0] ey0,
                                 input logic [8:0] ex1, input logic [7:0] ey1, input logic [2:0] ec);
        check({tag, "_x0"}, {23'd0, x0}, {23'd0, ex0});
        check({tag, "_y0"}, {24'd0, y0}, {24'd0, ey0});
        check({tag, "_x1"}, {23'd0, x1}, {23'd0, ex1});
        check({tag, "_y1"}, {24'd0, y1}, {24'd0, ey1});
        check({tag, "_color"}, {29'd0, color}, {29'd0, ec});
    endtask

    initial begin
        int st;
        int sc;
        int n;
        bus.s_address   = '0;
        bus.s_read      = 1'b0;
        bus.s_write     = 1'b0;
        bus.s_writedata = '0;
        reset = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.s_read = 1'b1; bus.s_address = ADDR_STATUS; #1;
        check("rst_waitreq", {31'd0, bus.s_waitrequest}, 32'd0);
        check("rst_rdata", bus.s_readdata, 32'd0);
        @(negedge clk);
        bus.s_read = 1'b0; reset = 1'b0;
        bus_read(ADDR_MODE,   32'd0, "post_rst_mode", st);
        bus_read(ADDR_STATUS, 32'd0, "post_rst_status", st);
        bus_read(ADDR_START,  32'd0, "post_rst_start", st);
        check_outputs("post_rst", 9'd0, 8'd0, 9'd0, 8'd0, 3'd0);
        check("post_rst_start_pulse", {31'd0, lda_start}, 32'd0);

        // Program a line, stall mode
        bus_write(ADDR_START, 32'h0000_C80A, 1'b0);
        check("start_x0_next_cycle", {23'd0, x0}, 32'd10);
        check("start_y0_next_cycle", {24'd0, y0}, 32'd100);
        bus_write(ADDR_END,   (32'd50 << 9) | 32'd200, 1'b0);
        bus_write(ADDR_COLOR, 32'd5, 1'b0);
        bus_read(ADDR_START, 32'h0000_C80A, "rb_start", st);
        bus_read(ADDR_END,   (32'd50 << 9) | 32'd200, "rb_end", st);
        bus_read(ADDR_COLOR, 32'd5, "rb_color", st);

        sc = start_cnt;
        done_delay = 6;
        bus_write(ADDR_GO, 32'h1234_5678, 1'b0);
        check("go_start_high", {31'd0, lda_start}, 32'd1);
        check_outputs("draw", 9'd10, 8'd100, 9'd200, 8'd50, 3'd5);
        @(posedge clk); #1;
        check("go_start_low", {31'd0, lda_start}, 32'd0);

        // Stall-mode STATUS read held until the cycle after done
        bus_read(ADDR_STATUS, 32'd0, "stall_status", st);
        check("stall_seen", {31'd0, (st > 0)}, 32'd1);
        check("stall_release_cycle", acc_cyc, done_cyc + 1);
        check("stall_one_pulse", start_cnt, sc + 1);

        // Poll mode
        bus_write(ADDR_MODE, 32'd1, 1'b0);
        bus_read(ADDR_MODE, 32'd1, "mode_poll", st);
        done_delay = 20;
        bus_write(ADDR_GO, 32'd0, 1'b0);
        bus_read(ADDR_STATUS, 32'd1, "poll_status_busy", st);
        check("poll_no_stall", st, 32'd0);
        bus_write(ADDR_START, 32'd0, 1'b0);
        check("poll_x0_kept", {23'd0, x0}, 32'd10);
        bus_read(ADDR_START, 32'h0000_C80A, "poll_start_kept", st);
        bus_write(ADDR_COLOR, 32'd2, 1'b0);
        bus_read(ADDR_COLOR, 32'd5, "poll_color_kept", st);
        bus_read(ADDR_MODE, 32'd1, "poll_mode_busy", st);
        n = 0;
        while (!lda_done && n < WAIT_LIMIT) begin
            @(negedge clk); n++;
        end
        if (!lda_done) check("poll_done_bound", {31'd0, lda_done}, 32'd1);
        bus_read(ADDR_STATUS, 32'd0, "poll_status_idle", st);

        // lda_done ignored in S_IDLE and S_START
        auto_done = 1'b0;
        @(negedge clk); done_force = 1'b1;
        @(negedge clk); done_force = 1'b0;
        bus_read(ADDR_STATUS, 32'd0, "idle_done_ignored", st);
        sc = start_cnt;
        bus_write(ADDR_GO, 32'd0, 1'b1);
        check("go2_start_high", {31'd0, lda_start}, 32'd1);
        repeat (3) @(posedge clk);
        bus_read(ADDR_STATUS, 32'd1, "start_done_ignored", st);
        bus_read(ADDR_STATUS, 32'd1, "still_busy", st);
        check("go2_one_pulse", start_cnt, sc + 1);

        // Back to stall mode while busy, then reset mid-draw
        bus_write(ADDR_MODE, 32'd0, 1'b0);
        @(negedge clk);
        bus.s_read = 1'b1; bus.s_address = ADDR_START; #1;
        check("busy_stall_on", {31'd0, bus.s_waitrequest}, 32'd1);
        reset = 1'b1; #1;
        check("rst_busy_waitreq", {31'd0, bus.s_waitrequest}, 32'd0);
        check("rst_busy_rdata", bus.s_readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0; bus.s_read = 1'b0; #1;
        check_outputs("rst_busy", 9'd0, 8'd0, 9'd0, 8'd0, 3'd0);
        bus_read(ADDR_STATUS, 32'd0, "rst_busy_status", st);
        bus_read(ADDR_MODE,   32'd0, "rst_busy_mode", st);
        check("rst_no_pulse", start_cnt, sc + 1);

        // Unmapped addresses and write-only GO
        bus_write(ADDR_START, 32'h0000_C80A, 1'b0);
        bus_write(ADDR_COLOR, 32'd3, 1'b0);
        bus_read(3'd7,    32'd0, "addr7_reads_0", st);
        bus_read(ADDR_GO, 32'd0, "go_reads_0", st);
        bus_write(3'd6, 32'hFFFF_FFFF, 1'b0);
        bus_read(ADDR_START, 32'h0000_C80A, "addr6_start_kept", st);
        bus_read(ADDR_END,   32'd0, "addr6_end_kept", st);
        bus_read(ADDR_COLOR, 32'd3, "addr6_color_kept", st);
        bus_read(ADDR_MODE,  32'd0, "addr6_mode_kept", st);
        bus_read(ADDR_STATUS, 32'd0, "addr6_status_idle", st);
        check("addr6_no_pulse", start_cnt, sc + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
